// File: rtl/life_solver_rules.sv
// Purpose : generation solver for a Game-of-Life style arena. It streams rows through a
//           3-row window and writes each new row back in place. The birth/survive rules,
//           the torus or dead-edge boundary and an early stop on a stable pattern are
//           selected at run time.
// Latency : each generation takes 2*ARENA_HEIGHT+2 cycles. ready rises the cycle after
//           the last row write of a run.
// Backpr. : none on the memory side (combinational read, one write per WRITE cycle). The
//           controller waits on ready. abort drops the run at the next edge and gates the
//           strobe in that cycle.
// Ports   : clk/reset_n; start/abort/ready handshake; run configuration
//           (generations_count, birth_mask, survive_mask, wrap_mode, stop_on_stable);
//           arena row memory port (arena_row_select, arena_columns, arena_columns_new,
//           arena_columns_write); status (generations_done, population, stable).
module life_solver_rules #(
    parameter int ARENA_WIDTH   = 10,
    parameter int ARENA_HEIGHT  = 10,
    parameter int ROW_SEL_WIDTH = 10,
    parameter int POP_WIDTH     = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic                     abort,
    output logic                     ready,
    input  logic [31:0]              generations_count,
    input  logic [8:0]               birth_mask,
    input  logic [8:0]               survive_mask,
    input  logic                     wrap_mode,
    input  logic                     stop_on_stable,
    output logic [ROW_SEL_WIDTH-1:0] arena_row_select,
    input  logic [ARENA_WIDTH-1:0]   arena_columns,
    output logic [ARENA_WIDTH-1:0]   arena_columns_new,
    output logic                     arena_columns_write,
    output logic [31:0]              generations_done,
    output logic [POP_WIDTH-1:0]     population,
    output logic                     stable
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ_LAST,
        S_READ_ROW0,
        S_READ_NEXT,
        S_WRITE
    } state_t;

    localparam logic [ROW_SEL_WIDTH-1:0] LAST_ROW = ROW_SEL_WIDTH'(ARENA_HEIGHT - 1);

    state_t                   state_q;
    logic [ROW_SEL_WIDTH-1:0] row_q;
    logic [ROW_SEL_WIDTH-1:0] sel_q;
    logic                     wr_q;
    logic                     ready_q;
    logic [ARENA_WIDTH-1:0]   prev_q;
    logic [ARENA_WIDTH-1:0]   cur_q;
    logic [ARENA_WIDTH-1:0]   next_q;
    logic [ARENA_WIDTH-1:0]   row0_q;
    logic                     changed_q;
    logic [POP_WIDTH-1:0]     acc_q;
    logic [31:0]              remaining_q;
    logic [8:0]               birth_q;
    logic [8:0]               survive_q;
    logic                     wrap_q;
    logic                     sos_q;
    logic [31:0]              gen_done_q;
    logic [POP_WIDTH-1:0]     pop_q;
    logic                     stable_q;

    logic [ARENA_WIDTH-1:0]   rule_row_d;
    logic [POP_WIDTH-1:0]     rule_pop_d;
    logic                     changed_d;
    logic [ROW_SEL_WIDTH-1:0] row_inc_d;
    logic [ROW_SEL_WIDTH-1:0] sel_next_d;

    // Live neighbour count of one column. The vertical neighbours come from prev/next.
    // The left and right columns either wrap around or are treated as dead.
    function automatic logic [3:0] nb_count(
        input logic [ARENA_WIDTH-1:0] p,
        input logic [ARENA_WIDTH-1:0] c,
        input logic [ARENA_WIDTH-1:0] n,
        input int                     col,
        input logic                   wrap
    );
        int         lc;
        int         rc;
        logic [3:0] cnt;
        lc  = (col == 0) ? ARENA_WIDTH - 1 : col - 1;
        rc  = (col == ARENA_WIDTH - 1) ? 0 : col + 1;
        cnt = {3'b000, p[col]} + {3'b000, n[col]};
        if (wrap || col != 0) begin
            cnt = cnt + {3'b000, p[lc]} + {3'b000, c[lc]} + {3'b000, n[lc]};
        end
        if (wrap || col != ARENA_WIDTH - 1) begin
            cnt = cnt + {3'b000, p[rc]} + {3'b000, c[rc]} + {3'b000, n[rc]};
        end
        return cnt;
    endfunction

    // New value of the row held in cur_q. This is only meaningful in WRITE.
    always_comb begin
        rule_row_d = '0;
        rule_pop_d = '0;
        for (int col = 0; col < ARENA_WIDTH; col++) begin
            logic [3:0] n;
            n = nb_count(prev_q, cur_q, next_q, col, wrap_q);
            rule_row_d[col] = cur_q[col] ? survive_q[n] : birth_q[n];
            rule_pop_d      = rule_pop_d + POP_WIDTH'(rule_row_d[col]);
        end
    end

    // The change flag includes the row being written now, so the stability decision at
    // the last row sees the whole generation.
    assign changed_d = changed_q | (|(rule_row_d ^ cur_q));

    // Row select for the next READ_NEXT: one row ahead, except on the last row. There the
    // window's lower neighbour does not come from memory, so the select just stays on r.
    assign row_inc_d  = row_q + ROW_SEL_WIDTH'(1);
    assign sel_next_d = (row_inc_d == LAST_ROW) ? row_inc_d : row_inc_d + ROW_SEL_WIDTH'(1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            row_q       <= '0;
            sel_q       <= '0;
            wr_q        <= 1'b0;
            ready_q     <= 1'b1;
            prev_q      <= '0;
            cur_q       <= '0;
            next_q      <= '0;
            row0_q      <= '0;
            changed_q   <= 1'b0;
            acc_q       <= '0;
            remaining_q <= '0;
            birth_q     <= '0;
            survive_q   <= '0;
            wrap_q      <= 1'b0;
            sos_q       <= 1'b0;
            gen_done_q  <= '0;
            pop_q       <= '0;
            stable_q    <= 1'b0;
        end else if (state_q != S_IDLE && abort) begin
            // Abandon the run. The completed-generation status is kept.
            state_q  <= S_IDLE;
            ready_q  <= 1'b1;
            wr_q     <= 1'b0;
            sel_q    <= '0;
            stable_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    // abort wins over start: a simultaneous abort blocks the run.
                    if (start && !abort && generations_count != 32'd0) begin
                        remaining_q <= generations_count;
                        birth_q     <= birth_mask;
                        survive_q   <= survive_mask;
                        wrap_q      <= wrap_mode;
                        sos_q       <= stop_on_stable;
                        gen_done_q  <= '0;
                        stable_q    <= 1'b0;
                        ready_q     <= 1'b0;
                        sel_q       <= LAST_ROW;
                        state_q     <= S_READ_LAST;
                    end
                end
                S_READ_LAST: begin
                    prev_q  <= wrap_q ? arena_columns : '0;
                    sel_q   <= '0;
                    state_q <= S_READ_ROW0;
                end
                S_READ_ROW0: begin
                    cur_q     <= arena_columns;
                    row0_q    <= arena_columns;
                    changed_q <= 1'b0;
                    acc_q     <= '0;
                    row_q     <= '0;
                    // Row 1 is the lower neighbour of row 0. This holds because the
                    // arena has at least 3 rows.
                    sel_q     <= ROW_SEL_WIDTH'(1);
                    state_q   <= S_READ_NEXT;
                end
                S_READ_NEXT: begin
                    if (row_q != LAST_ROW) begin
                        next_q <= arena_columns;
                    end else begin
                        // Row 0 has already been overwritten in memory, so its saved
                        // original copy is used instead.
                        next_q <= wrap_q ? row0_q : '0;
                    end
                    sel_q   <= row_q;
                    wr_q    <= 1'b1;
                    state_q <= S_WRITE;
                end
                S_WRITE: begin
                    wr_q      <= 1'b0;
                    prev_q    <= cur_q;
                    cur_q     <= next_q;
                    changed_q <= changed_d;
                    acc_q     <= acc_q + rule_pop_d;
                    if (row_q != LAST_ROW) begin
                        row_q   <= row_inc_d;
                        sel_q   <= sel_next_d;
                        state_q <= S_READ_NEXT;
                    end else begin
                        gen_done_q <= gen_done_q + 32'd1;
                        pop_q      <= acc_q + rule_pop_d;
                        if (remaining_q == 32'd1) begin
                            ready_q <= 1'b1;
                            sel_q   <= '0;
                            state_q <= S_IDLE;
                        end else if (sos_q && !changed_d) begin
                            stable_q <= 1'b1;
                            ready_q  <= 1'b1;
                            sel_q    <= '0;
                            state_q  <= S_IDLE;
                        end else begin
                            remaining_q <= remaining_q - 32'd1;
                            sel_q       <= LAST_ROW;
                            state_q     <= S_READ_LAST;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b1;
                    wr_q    <= 1'b0;
                    sel_q   <= '0;
                end
            endcase
        end
    end

    assign ready               = ready_q;
    assign arena_row_select    = sel_q;
    // abort also gates the strobe in the cycle it arrives, so no write lands.
    assign arena_columns_write = wr_q & ~abort;
    assign arena_columns_new   = rule_row_d;
    assign generations_done    = gen_done_q;
    assign population          = pop_q;
    assign stable              = stable_q;

endmodule

// File: tb/tb_life_solver_rules.sv
module tb_life_solver_rules;

    localparam int W       = 8;
    localparam int H       = 8;
    localparam int RSW     = 10;
    localparam int PW      = 16;
    localparam int GEN_CYC = 2 * H + 2;

    typedef logic [H-1:0][W-1:0] arena_t;   // a[row][col]

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic           start = 1'b0;
    logic           abort = 1'b0;
    logic           ready;
    logic [31:0]    generations_count = '0;
    logic [8:0]     birth_mask = '0;
    logic [8:0]     survive_mask = '0;
    logic           wrap_mode = 1'b0;
    logic           stop_on_stable = 1'b0;
    logic [RSW-1:0] arena_row_select;
    logic [W-1:0]   arena_columns;
    logic [W-1:0]   arena_columns_new;
    logic           arena_columns_write;
    logic [31:0]    generations_done;
    logic [PW-1:0]  population;
    logic           stable;

    int checks = 0;
    int errors = 0;

    life_solver_rules #(
        .ARENA_WIDTH  (W),
        .ARENA_HEIGHT (H),
        .ROW_SEL_WIDTH(RSW),
        .POP_WIDTH    (PW)
    ) dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .start              (start),
        .abort              (abort),
        .ready              (ready),
        .generations_count  (generations_count),
        .birth_mask         (birth_mask),
        .survive_mask       (survive_mask),
        .wrap_mode          (wrap_mode),
        .stop_on_stable     (stop_on_stable),
        .arena_row_select   (arena_row_select),
        .arena_columns      (arena_columns),
        .arena_columns_new  (arena_columns_new),
        .arena_columns_write(arena_columns_write),
        .generations_done   (generations_done),
        .population         (population),
        .stable             (stable)
    );

    always #5 clk = ~clk;

    // Arena memory plus write-protocol monitor
    arena_t mem = '0;
    arena_t seed = '0;
    logic   load_en = 1'b0;
    int     cyc = 0;
    int     wr_count = 0;
    int     order_err = 0;
    int     spacing_err = 0;
    int     last_wr_cyc = 0;
    int     exp_row = 0;

    assign arena_columns = (arena_row_select < RSW'(H)) ? mem[arena_row_select[2:0]] : '0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (arena_columns_write) begin
            mem[arena_row_select[2:0]] <= arena_columns_new;
            wr_count <= wr_count + 1;
            if (int'(arena_row_select) != exp_row || ready) order_err <= order_err + 1;
            if (exp_row != 0 && cyc - last_wr_cyc != 2) spacing_err <= spacing_err + 1;
            last_wr_cyc <= cyc;
            exp_row <= (exp_row == H - 1) ? 0 : exp_row + 1;
        end else begin
            if (load_en) mem <= seed;
            if (ready) exp_row <= 0;
        end
    end

    // Reference model: plain neighbourhood counting on a 2-D grid
    function automatic arena_t life_step(input arena_t a, input logic [8:0] b,
                                         input logic [8:0] s, input logic wrap);
        arena_t o;
        int n, rr, cc;
        o = '0;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                n = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        if (dr == 0 && dc == 0) continue;
                        rr = r + dr;
                        cc = c + dc;
                        if (wrap) begin
                            rr = (rr + H) % H;
                            cc = (cc + W) % W;
                        end else if (rr < 0 || rr >= H || cc < 0 || cc >= W) begin
                            continue;
                        end
                        n += int'(a[rr][cc]);
                    end
                end
                o[r][c] = a[r][c] ? s[n] : b[n];
            end
        end
        return o;
    endfunction

    task automatic model_run(input arena_t a, input int g, input logic [8:0] b,
                             input logic [8:0] s, input logic wrap, input logic sos,
                             output arena_t res, output int done, output int pop,
                             output logic stab);
        arena_t nx;
        logic   same;
        res  = a;
        done = 0;
        stab = 1'b0;
        for (int i = 1; i <= g; i++) begin
            nx   = life_step(res, b, s, wrap);
            same = (nx == res);
            res  = nx;
            done = i;
            if (i < g && sos && same) begin
                stab = 1'b1;
                break;
            end
        end
        pop = $countones(res);
    endtask

    task automatic load_arena(input arena_t a);
        seed = a;
        @(negedge clk);
        load_en = 1'b1;
        @(negedge clk);
        load_en = 1'b0;
    endtask

    // Starts a run, scrambles the configuration inputs mid-run and returns the number of
    // cycles until ready (-1 if the run never finished).
    task automatic run_gens(input int g, input logic [8:0] b, input logic [8:0] s,
                            input logic wrap, input logic sos, output int cycles);
        @(negedge clk);
        generations_count = g;
        birth_mask        = b;
        survive_mask      = s;
        wrap_mode         = wrap;
        stop_on_stable    = sos;
        start             = 1'b1;
        @(negedge clk);
        start             = 1'b0;
        birth_mask        = 9'($urandom);
        survive_mask      = 9'($urandom);
        wrap_mode         = 1'($urandom);
        stop_on_stable    = 1'($urandom);
        generations_count = $urandom;
        cycles = 0;
        while (!ready && cycles < 5000) begin
            @(negedge clk);
            cycles++;
        end
        if (!ready) cycles = -1;
    endtask

    arena_t blinker_h, blinker_v, block_p, glider_p;

    task automatic test_reset();
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", ready); end
        checks++; if (arena_columns_write !== 1'b0) begin errors++; $display("FAIL reset_write: got %b want 0", arena_columns_write); end
        checks++; if (arena_row_select !== '0) begin errors++; $display("FAIL reset_sel: got %0d want 0", arena_row_select); end
        checks++; if (generations_done !== 32'd0) begin errors++; $display("FAIL reset_gens: got %0d want 0", generations_done); end
        checks++; if (population !== '0) begin errors++; $display("FAIL reset_pop: got %0d want 0", population); end
        checks++; if (stable !== 1'b0) begin errors++; $display("FAIL reset_stable: got %b want 0", stable); end
    endtask

    task automatic test_blinker();
        int cyc_n;
        load_arena(blinker_h);
        run_gens(1, 9'h008, 9'h00C, 1'b1, 1'b0, cyc_n);
        checks++; if (cyc_n !== GEN_CYC) begin errors++; $display("FAIL blinker_cycles: got %0d want %0d", cyc_n, GEN_CYC); end
        checks++; if (mem !== blinker_v) begin errors++; $display("FAIL blinker_arena: got %h want %h", mem, blinker_v); end
        checks++; if (population !== 16'd3) begin errors++; $display("FAIL blinker_pop: got %0d want 3", population); end
        checks++; if (generations_done !== 32'd1) begin errors++; $display("FAIL blinker_gens: got %0d want 1", generations_done); end
        checks++; if (stable !== 1'b0) begin errors++; $display("FAIL blinker_stable: got %b want 0", stable); end
    endtask

    task automatic test_back_to_back();
        int cyc_n, w0, sp0;
        load_arena(blinker_h);
        w0  = wr_count;
        sp0 = spacing_err;
        run_gens(2, 9'h008, 9'h00C, 1'b1, 1'b0, cyc_n);
        checks++; if (cyc_n !== 2 * GEN_CYC) begin errors++; $display("FAIL b2b_cycles: got %0d want %0d", cyc_n, 2 * GEN_CYC); end
        checks++; if (mem !== blinker_h) begin errors++; $display("FAIL b2b_arena: got %h want %h", mem, blinker_h); end
        checks++; if (wr_count - w0 !== 2 * H) begin errors++; $display("FAIL b2b_writes: got %0d want %0d", wr_count - w0, 2 * H); end
        checks++; if (spacing_err !== sp0) begin errors++; $display("FAIL b2b_spacing: got %0d bad gaps want 0", spacing_err - sp0); end
        checks++; if (generations_done !== 32'd2) begin errors++; $display("FAIL b2b_gens: got %0d want 2", generations_done); end
    endtask

    task automatic test_stable();
        int cyc_n, w0;
        load_arena(block_p);
        w0 = wr_count;
        run_gens(100, 9'h008, 9'h00C, 1'b0, 1'b1, cyc_n);
        checks++; if (cyc_n !== GEN_CYC) begin errors++; $display("FAIL stable_cycles: got %0d want %0d", cyc_n, GEN_CYC); end
        checks++; if (stable !== 1'b1) begin errors++; $display("FAIL stable_flag: got %b want 1", stable); end
        checks++; if (generations_done !== 32'd1) begin errors++; $display("FAIL stable_gens: got %0d want 1", generations_done); end
        checks++; if (population !== 16'd4) begin errors++; $display("FAIL stable_pop: got %0d want 4", population); end
        checks++; if (mem !== block_p) begin errors++; $display("FAIL stable_arena: got %h want %h", mem, block_p); end
        checks++; if (wr_count - w0 !== H) begin errors++; $display("FAIL stable_writes: got %0d want %0d", wr_count - w0, H); end
    endtask

    task automatic test_glider(input logic wrap);
        int cyc_n, done, pop;
        arena_t exp_a, moved;
        logic stab;
        load_arena(glider_p);
        model_run(glider_p, 4, 9'h008, 9'h00C, wrap, 1'b0, exp_a, done, pop, stab);
        run_gens(4, 9'h008, 9'h00C, wrap, 1'b0, cyc_n);
        checks++; if (mem !== exp_a) begin errors++; $display("FAIL glider_arena wrap=%0b: got %h want %h", wrap, mem, exp_a); end
        checks++; if (population !== 16'(pop)) begin errors++; $display("FAIL glider_pop wrap=%0b: got %0d want %0d", wrap, population, pop); end
        checks++; if (cyc_n !== 4 * GEN_CYC) begin errors++; $display("FAIL glider_cycles: got %0d want %0d", cyc_n, 4 * GEN_CYC); end
        if (wrap) begin
            moved = '0;
            moved[6] = 8'h80;
            moved[7] = 8'h01;
            moved[0] = 8'hC1;
            checks++; if (mem !== moved) begin errors++; $display("FAIL glider_torus_shape: got %h want %h", mem, moved); end
            checks++; if (population !== 16'd5) begin errors++; $display("FAIL glider_torus_pop: got %0d want 5", population); end
        end
    endtask

    task automatic test_highlife();
        int cyc_n;
        logic [63:0] rnd;
        arena_t a, exp_a;
        logic wrap;
        rnd = {$urandom, $urandom};
        a   = rnd;
        load_arena(a);
        for (int g = 1; g <= 5; g++) begin
            wrap  = (g % 2 == 1);
            exp_a = life_step(a, 9'h048, 9'h00C, wrap);
            run_gens(1, 9'h048, 9'h00C, wrap, 1'b0, cyc_n);
            checks++; if (mem !== exp_a) begin errors++; $display("FAIL highlife_arena gen %0d: got %h want %h", g, mem, exp_a); end
            checks++; if (population !== 16'($countones(exp_a))) begin errors++; $display("FAIL highlife_pop gen %0d: got %0d want %0d", g, population, $countones(exp_a)); end
            checks++; if (cyc_n !== GEN_CYC) begin errors++; $display("FAIL highlife_cycles gen %0d: got %0d want %0d", g, cyc_n, GEN_CYC); end
            a = exp_a;
        end
    endtask

    task automatic test_random_rules();
        int cyc_n, done, pop, g;
        logic [63:0] rnd;
        logic [8:0] b, s;
        logic wrap, sos, stab;
        arena_t a, exp_a;
        for (int it = 0; it < 6; it++) begin
            rnd  = {$urandom, $urandom};
            a    = rnd;
            b    = 9'($urandom) & 9'h1FE;   // no birth from nothing
            s    = 9'($urandom);
            wrap = 1'($urandom);
            sos  = (it % 2 == 0);
            g    = $urandom_range(1, 4);
            if (it == 5) begin
                // Still-life rule: every cell keeps its value, so the run stops early.
                b = 9'h000;
                s = 9'h1FF;
                g = 3;
            end
            load_arena(a);
            model_run(a, g, b, s, wrap, sos, exp_a, done, pop, stab);
            run_gens(g, b, s, wrap, sos, cyc_n);
            checks++; if (mem !== exp_a) begin errors++; $display("FAIL rand_arena it %0d: got %h want %h", it, mem, exp_a); end
            checks++; if (population !== 16'(pop)) begin errors++; $display("FAIL rand_pop it %0d: got %0d want %0d", it, population, pop); end
            checks++; if (generations_done !== 32'(done)) begin errors++; $display("FAIL rand_gens it %0d: got %0d want %0d", it, generations_done, done); end
            checks++; if (stable !== stab) begin errors++; $display("FAIL rand_stable it %0d: got %b want %b", it, stable, stab); end
            checks++; if (cyc_n !== done * GEN_CYC) begin errors++; $display("FAIL rand_cycles it %0d: got %0d want %0d", it, cyc_n, done * GEN_CYC); end
        end
    endtask

    task automatic test_abort();
        int w0;
        logic [PW-1:0] pop0;
        load_arena(blinker_h);
        pop0 = population;
        w0   = wr_count;
        @(negedge clk);
        generations_count = 5;
        birth_mask        = 9'h008;
        survive_mask      = 9'h00C;
        wrap_mode         = 1'b1;
        stop_on_stable    = 1'b0;
        start             = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        abort = 1'b1;
        #1;
        checks++; if (arena_columns_write !== 1'b0) begin errors++; $display("FAIL abort_gate: got %b want 0", arena_columns_write); end
        @(negedge clk);
        abort = 1'b0;
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL abort_ready: got %b want 1", ready); end
        checks++; if (generations_done !== 32'd0) begin errors++; $display("FAIL abort_gens: got %0d want 0", generations_done); end
        checks++; if (population !== pop0) begin errors++; $display("FAIL abort_pop: got %0d want %0d", population, pop0); end
        checks++; if (stable !== 1'b0) begin errors++; $display("FAIL abort_stable: got %b want 0", stable); end
        repeat (40) @(negedge clk);
        checks++; if (wr_count - w0 !== 2) begin errors++; $display("FAIL abort_writes: got %0d want 2", wr_count - w0); end
    endtask

    task automatic test_idle_ignores();
        int w0;
        logic [31:0] g0;
        w0 = wr_count;
        g0 = generations_done;
        @(negedge clk);
        generations_count = 3;
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        generations_count = 0;
        @(negedge clk);
        start = 1'b0;
        repeat (30) @(negedge clk);
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL idle_ready: got %b want 1", ready); end
        checks++; if (wr_count !== w0) begin errors++; $display("FAIL idle_writes: got %0d want %0d", wr_count, w0); end
        checks++; if (generations_done !== g0) begin errors++; $display("FAIL idle_gens: got %0d want %0d", generations_done, g0); end
    endtask

    task automatic test_reset_midrun();
        @(negedge clk);
        generations_count = 3;
        birth_mask        = 9'h008;
        survive_mask      = 9'h00C;
        wrap_mode         = 1'b1;
        stop_on_stable    = 1'b0;
        start             = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (25) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready: got %b want 1", ready); end
        checks++; if (arena_columns_write !== 1'b0) begin errors++; $display("FAIL rst_mid_write: got %b want 0", arena_columns_write); end
        checks++; if (arena_row_select !== '0) begin errors++; $display("FAIL rst_mid_sel: got %0d want 0", arena_row_select); end
        checks++; if (generations_done !== 32'd0) begin errors++; $display("FAIL rst_mid_gens: got %0d want 0", generations_done); end
        checks++; if (population !== '0) begin errors++; $display("FAIL rst_mid_pop: got %0d want 0", population); end
        checks++; if (stable !== 1'b0) begin errors++; $display("FAIL rst_mid_stable: got %b want 0", stable); end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_write_protocol();
        checks++; if (order_err !== 0) begin errors++; $display("FAIL write_order: got %0d bad writes want 0", order_err); end
        checks++; if (spacing_err !== 0) begin errors++; $display("FAIL write_spacing: got %0d bad gaps want 0", spacing_err); end
    endtask

    initial begin
        blinker_h = '0;
        blinker_h[3] = 8'b0001_1100;
        blinker_v = '0;
        blinker_v[2] = 8'b0000_1000;
        blinker_v[3] = 8'b0000_1000;
        blinker_v[4] = 8'b0000_1000;
        block_p = '0;
        block_p[2] = 8'b0000_1100;
        block_p[3] = 8'b0000_1100;
        glider_p = '0;
        glider_p[5] = 8'b0100_0000;
        glider_p[6] = 8'b1000_0000;
        glider_p[7] = 8'b1110_0000;

        test_reset();
        test_blinker();
        test_back_to_back();
        test_stable();
        test_glider(1'b1);
        test_glider(1'b0);
        test_highlife();
        test_random_rules();
        test_abort();
        test_idle_ignores();
        test_write_protocol();
        test_reset_midrun();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
